// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types for the instruction-fetch stage: instruction
//                word types, fetch FSM states, NOP constant and skid entry.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef logic [31:0] instrType;
    typedef logic [6:0]  opCode;
    typedef logic [2:0]  func;

    typedef enum logic [0:0] {
        FETCH   = 1'b0,
        DISCARD = 1'b1
    } fetchState;

    localparam instrType NOP = '0;

    typedef struct packed {
        instrType                   instr;
        logic [WIDTH_DEFAULT-1:0]   pc;
    } skidEntry;

endpackage
`default_nettype wire

// File: rtl/fetch_skid.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_skid
//  Description : One-entry skid buffer holding an instruction that arrived
//                while decode was stalled.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                flush         - drop any held entry (redirect)
//                push/pushEntry- capture an entry
//                pop           - release the held entry
//                full/entry    - occupancy flag and held entry
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid
    import fetch_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     flush,
    input  logic     push,
    input  logic     pop,
    input  skidEntry pushEntry,
    output logic     full,
    output skidEntry entry
);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            full  <= 1'b0;
            entry <= '0;
        end else if (push) begin
            full  <= 1'b1;
            entry <= pushEntry;
        end else if (pop) begin
            full  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch.sv
`default_nettype none
// ============================================================================
//  Module      : fetch
//  Description : Instruction-fetch stage. Owns the PC, issues req/ack fetches
//                to instruction memory, honours decode stall via a one-entry
//                skid buffer and accepts branch/jump redirects.
//  Ports       : clk, rst                  - clock, sync active-high reset
//                stall                     - decode cannot accept
//                pcSrc, pcTarget           - redirect request / address
//                imemReq, imemAddr         - memory request / word address
//                imemAck, imemData         - memory completion / data
//                instr, instrValid, pc, pcPlus4 - registered outputs to decode
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             pcSrc,
    input  logic [WIDTH-1:0] pcTarget,
    output logic             imemReq,
    output logic [WIDTH-1:0] imemAddr,
    input  logic             imemAck,
    input  logic [31:0]      imemData,
    output instrType         instr,
    output logic             instrValid,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pcPlus4
);

    localparam logic [WIDTH-1:0] c_FOUR = WIDTH'(4);

    fetchState        r_state;
    logic [WIDTH-1:0] r_fetchPc;
    // Address of the abandoned request; it must stay on the bus until the
    // stale ack arrives even though fetchPc already holds the target.
    logic [WIDTH-1:0] r_discardAddr;

    logic             w_skidFull;
    skidEntry         w_skidEntry;
    skidEntry         w_pushEntry;
    logic             w_ack;
    logic             w_outFree;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_target;

    assign imemReq  = !rst && ((r_state == FETCH && !w_skidFull) || r_state == DISCARD);
    assign imemAddr = (r_state == DISCARD) ? r_discardAddr : r_fetchPc;

    // An ack only counts against a live request.
    assign w_ack     = imemAck && imemReq;
    assign w_outFree = !stall || !instrValid;
    assign w_target  = {pcTarget[WIDTH-1:2], 2'b00};

    assign w_push = (r_state == FETCH) && !pcSrc && w_ack && !w_outFree;
    assign w_pop  = (r_state == FETCH) && !pcSrc && w_skidFull && !stall;

    assign w_pushEntry.instr = imemData;
    assign w_pushEntry.pc    = r_fetchPc;

    fetch_skid u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (pcSrc),
        .push      (w_push),
        .pop       (w_pop),
        .pushEntry (w_pushEntry),
        .full      (w_skidFull),
        .entry     (w_skidEntry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= FETCH;
            r_fetchPc     <= RESET_PC;
            r_discardAddr <= RESET_PC;
            instr         <= NOP;
            instrValid    <= 1'b0;
            pc            <= RESET_PC;
            pcPlus4       <= RESET_PC + c_FOUR;
        end else if (pcSrc) begin
            instrValid <= 1'b0;
            r_fetchPc  <= w_target;
            if (r_state == FETCH) begin
                if (imemReq && !w_ack) begin
                    r_state       <= DISCARD;
                    r_discardAddr <= r_fetchPc;
                end
            end else if (w_ack) begin
                // Stale request finished this cycle; nothing left to drop.
                r_state <= FETCH;
            end
        end else if (r_state == DISCARD) begin
            if (w_ack) begin
                r_state <= FETCH;
            end
        end else if (w_skidFull) begin
            if (!stall) begin
                instr      <= w_skidEntry.instr;
                pc         <= w_skidEntry.pc[WIDTH-1:0];
                pcPlus4    <= w_skidEntry.pc[WIDTH-1:0] + c_FOUR;
                instrValid <= 1'b1;
            end
        end else if (w_ack) begin
            r_fetchPc <= r_fetchPc + c_FOUR;
            if (w_outFree) begin
                instr      <= imemData;
                pc         <= r_fetchPc;
                pcPlus4    <= r_fetchPc + c_FOUR;
                instrValid <= 1'b1;
            end
        end else if (w_outFree) begin
            instrValid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch
//  Description : Self-checking bench for fetch. A wait-state memory model
//                feeds the main instance; accepted words are queued and
//                matched against every new output beat. A second instance
//                with RESET_PC=0xFFFF_FFFC covers address wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch;
    import fetch_pkg::*;

    localparam logic [31:0] c_TAG = 32'h8C00_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        pcSrc = 1'b0;
    logic [31:0] pcTarget = '0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck = 1'b0;
    logic [31:0] imemData = '0;
    instrType    instr;
    logic        instrValid;
    logic [31:0] pc;
    logic [31:0] pcPlus4;

    logic        imemReq2;
    logic [31:0] imemAddr2;
    logic        imemAck2;
    logic [31:0] imemData2;
    instrType    instr2;
    logic        instrValid2;
    logic [31:0] pc2;
    logic [31:0] pcPlus42;

    int checks   = 0;
    int failures = 0;
    int lat      = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    fetch #(.WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .stall(stall), .pcSrc(pcSrc), .pcTarget(pcTarget),
        .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
        .instr(instr), .instrValid(instrValid), .pc(pc), .pcPlus4(pcPlus4)
    );

    assign imemAck2  = imemReq2;
    assign imemData2 = imemAddr2 | c_TAG;

    fetch #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst), .stall(1'b0), .pcSrc(1'b0), .pcTarget(32'h0),
        .imemReq(imemReq2), .imemAddr(imemAddr2), .imemAck(imemAck2), .imemData(imemData2),
        .instr(instr2), .instrValid(instrValid2), .pc(pc2), .pcPlus4(pcPlus42)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Memory model and scoreboard, evaluated mid-cycle on the falling edge.
    int          cnt = 0;
    logic        discard_pending = 1'b0;
    logic        prev_hold = 1'b0;
    logic        prev_wait = 1'b0;
    logic        prev_rst  = 1'b1;
    logic [31:0] prev_addr = '0;

    always @(negedge clk) begin
        exp_t e;
        logic ack;
        ack = 1'b0;
        if (rst) begin
            sb.delete();
            cnt = 0;
            discard_pending = 1'b0;
            prev_hold = 1'b0;
            prev_wait = 1'b0;
        end else begin
            // New output beat: compare against the oldest accepted word.
            if (instrValid && !prev_hold) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_valid", {31'b0, instrValid}, 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("sb_pc", pc, e.pc);
                    check("sb_pcPlus4", pcPlus4, e.pc + 32'd4);
                    check("sb_instr", instr, e.data);
                end
            end
            // A request left hanging must persist unchanged.
            if (prev_wait && !prev_rst) begin
                check("hs_req_held", {31'b0, imemReq}, 32'h1);
                check("hs_addr_held", imemAddr, prev_addr);
            end
            if (imemReq) begin
                check("addr_aligned", {30'b0, imemAddr[1:0]}, 32'h0);
                if (cnt >= lat) begin
                    ack = 1'b1;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
            if (pcSrc) begin
                sb.delete();
                discard_pending = imemReq && !ack;
            end else if (ack) begin
                if (discard_pending) discard_pending = 1'b0;
                else begin
                    e.pc   = imemAddr;
                    e.data = imemAddr | c_TAG;
                    sb.push_back(e);
                end
            end
            prev_hold = stall && instrValid && !pcSrc;
            prev_wait = imemReq && !ack;
            prev_addr = imemAddr;
        end
        prev_rst = rst;
        imemAck  = ack;
        imemData = imemAddr | c_TAG;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with zero-wait memory.
        rst = 1'b1;
        step(3);
        check("rst_valid", {31'b0, instrValid}, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_pcPlus4", pcPlus4, 32'h4);
        check("rst_req", {31'b0, imemReq}, 32'h0);
        check("rst_pc2", pc2, 32'hFFFF_FFFC);
        rst = 1'b0;
        #1;
        check("t1_first_addr", imemAddr, 32'h0);
        check("t1_req", {31'b0, imemReq}, 32'h1);
        check("t6_first_addr", imemAddr2, 32'hFFFF_FFFC);
        step(1);
        check("t1_valid0", {31'b0, instrValid}, 32'h1);
        check("t1_pc0", pc, 32'h0);
        check("t1_pcPlus4_0", pcPlus4, 32'h4);
        check("t6_valid", {31'b0, instrValid2}, 32'h1);
        check("t6_pc", pc2, 32'hFFFF_FFFC);
        check("t6_pcPlus4", pcPlus42, 32'h0);
        check("t6_next_addr", imemAddr2, 32'h0);
        step(1);
        check("t1_pc4", pc, 32'h4);
        step(1);
        check("t1_pc8", pc, 32'h8);

        // Stall while 0x8 is shown and 0xC is acked into the skid.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("t3_hold_pc", pc, 32'h8);
            check("t3_hold_valid", {31'b0, instrValid}, 32'h1);
            check("t3_req_low", {31'b0, imemReq}, 32'h0);
        end

        // Release stall; next request sees a two-wait-state memory.
        lat   = 2;
        stall = 1'b0;
        step(1);
        check("t3_release_pc", pc, 32'hC);
        check("t3_release_valid", {31'b0, instrValid}, 32'h1);
        check("t2_addr0", imemAddr, 32'h10);
        check("t2_req", {31'b0, imemReq}, 32'h1);
        step(1);
        check("t2_addr1", imemAddr, 32'h10);
        check("t2_bubble1", {31'b0, instrValid}, 32'h0);
        step(1);
        check("t2_addr2", imemAddr, 32'h10);
        check("t2_bubble2", {31'b0, instrValid}, 32'h0);
        step(1);
        check("t2_valid", {31'b0, instrValid}, 32'h1);
        check("t2_pc", pc, 32'h10);
        check("t2_next_addr", imemAddr, 32'h14);

        // Redirect while 0x14 is outstanding.
        pcSrc    = 1'b1;
        pcTarget = 32'h40;
        step(1);
        pcSrc = 1'b0;
        check("t4_valid0", {31'b0, instrValid}, 32'h0);
        check("t4_stale_addr0", imemAddr, 32'h14);
        check("t4_stale_req0", {31'b0, imemReq}, 32'h1);
        step(1);
        check("t4_valid1", {31'b0, instrValid}, 32'h0);
        check("t4_stale_addr1", imemAddr, 32'h14);
        step(1);
        check("t4_valid2", {31'b0, instrValid}, 32'h0);
        check("t4_target_addr", imemAddr, 32'h40);
        lat = 0;
        step(1);
        check("t4_target_valid", {31'b0, instrValid}, 32'h1);
        check("t4_target_pc", pc, 32'h40);

        // Redirect coinciding with an ack; unaligned target.
        pcSrc    = 1'b1;
        pcTarget = 32'h43;
        step(1);
        pcSrc = 1'b0;
        check("t5_dropped", {31'b0, instrValid}, 32'h0);
        check("t5_addr", imemAddr, 32'h40);
        step(1);
        check("t5_pc40", pc, 32'h40);
        step(1);
        check("t5_pc44", pc, 32'h44);

        // Reset in the middle of a waited request.
        lat = 2;
        step(1);
        rst = 1'b1;
        step(1);
        check("mrst_valid", {31'b0, instrValid}, 32'h0);
        check("mrst_pc", pc, 32'h0);
        check("mrst_req", {31'b0, imemReq}, 32'h0);
        rst = 1'b0;
        lat = 0;
        #1;
        check("mrst_addr", imemAddr, 32'h0);
        step(1);
        check("mrst_restart_pc", pc, 32'h0);
        check("mrst_restart_instr", instr, c_TAG);
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
